slow_clk_monitor: RTL
=====================

// Module: slow_clk_monitor
// PURPOSE
//  Receive-side companion to the quiz's slow-clock divider. Samples a slow clock (nominal half-period
//  10 clk_in cycles) back into the clk_in domain, emits single-cycle rise/fall ticks, measures each
//  half-period, and reports lock/stall so quiz timers can trust, or distrust, the slow time base.
// PARAMETERS
//  CNT_W       8   width of half-period counter / measurement (saturating)
//  EXP_HALF    10  expected half-period in clk_in cycles
//  TOL         1   accepted deviation: |half_period - EXP_HALF| <= TOL
//  LOCK_EDGES  4   consecutive in-tolerance measurements required to lock
//  STALL_LIMIT 40  clk_in cycles without a detected edge before stall; must be > EXP_HALF+TOL and < 2^CNT_W
// PORTS
//  clk_in       input  1      system clock; the only clock
//  reset        input  1      asynchronous, active-high reset
//  slow_clk     input  1      slow clock under monitor, asynchronous to clk_in
//  rise_tick    output 1      1-cycle pulse per detected rising edge of slow_clk
//  fall_tick    output 1      1-cycle pulse per detected falling edge of slow_clk
//  half_period  output CNT_W  last measured half-period, in clk_in cycles
//  period_valid output 1      1-cycle strobe: half_period updated this cycle
//  lock         output 1      slow_clk stable within tolerance
//  stall        output 1      no edge seen for STALL_LIMIT cycles
//  err_count    output 8      saturating error count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, counter 0, good count 0, FSM = IDLE, sync chain 0.
//  Sync: s1 <= slow_clk; s2 <= s1; s3 <= s2. Edge detected when s2 != s3 (rise if s2=1). Ticks are
//   registered: high for exactly 1 cycle, 3 clk_in edges after the sampled slow_clk transition.
//  Counter cnt: increments each cycle, saturates at 2^CNT_W-1. On a detected edge, meas = cnt+1
//   (saturating); cnt <= 0. A steady toggle every N cycles therefore yields meas = N.
//  FSM (the state changes on the cycle of the detected edge; lock/stall are registered):
//   IDLE    - first edge: discard meas, -> ACQUIRE. Stall timeout -> STALLED.
//   ACQUIRE - per edge: half_period<=meas, period_valid=1; in-tol: good++; good==LOCK_EDGES -> LOCKED;
//             out-of-tol: good<=0, error event.
//   LOCKED  - lock=1; per edge: update half_period/period_valid; out-of-tol: error, good<=0, -> ACQUIRE.
//   STALLED - stall=1, lock=0; next edge: discard meas, good<=0, stall<=0, -> ACQUIRE.
//   Any state except STALLED: cnt+1 == STALL_LIMIT with no edge -> STALLED, error event.
//  Simultaneous: an edge in the same cycle as the stall threshold wins (measures, no stall).
//  Glitch shorter than one clk_in period may be missed; a missed pair of edges reads as a long period.
//  Reset mid-operation: immediate return to reset values; any in-flight tick is dropped.
//  half_period holds its value between updates; it is not cleared on stall.
// CONFIGURATION
//  SLOW_CLK_MON_ERRCNT_EN defined: err_count increments by 1 per error event (out-of-tol measurement
//   or stall entry), saturates at 255, and is cleared only by reset.
//  Not defined: err_count is tied to 8'd0 and no counter logic is instantiated.
// STRUCTURE
//  slow_clk_mon_pkg: FSM state encoding (IDLE, ACQUIRE, LOCKED, STALLED) and default constants
//   (EXP_HALF=10, TOL=1, LOCK_EDGES=4, STALL_LIMIT=40).
//  Sub-module bit_sync_2ff (s1/s2 chain, async reset) is instantiated once; the other logic is inline.
// TESTING
//  1 Toggle slow_clk every 10 clk_in cycles -> first edge discarded; half_period=10 and period_valid
//    on each later edge; lock=1 after 4 in-tol edges; alternating rise/fall ticks.
//  2 Locked, one half-period of 13 -> period_valid with half_period=13, lock drops, state ACQUIRE,
//    err_count=1 (0 if macro off); 4 good edges relock.
//  3 Locked, hold slow_clk static -> stall=1 and lock=0 on the 40th cycle after the last edge;
//    next toggle -> stall=0, no period_valid for that edge, relock after 4 more good edges.
//  4 Half-period 9 and 11 alternating -> stays locked; 8 and 12 -> never locks.
//  5 Assert reset mid-half-period while locked -> all outputs 0 immediately; IDLE on release.
//  6 Edge arriving on exactly the 40th idle cycle -> no stall, half_period=40, out-of-tol error.

Source files
------------

// File: rtl/slow_clk_mon_pkg.sv
// Shared definitions for the slow-clock monitor: FSM state encoding,
// default timing constants and the tolerance helper.
package slow_clk_mon_pkg;

    // Monitor FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        STALLED = 2'd3
    } mon_state_e;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_EXP_HALF    = 10;
    localparam int DEF_TOL         = 1;
    localparam int DEF_LOCK_EDGES  = 4;
    localparam int DEF_STALL_LIMIT = 40;

    // True when a measured half-period lies inside exp_half +/- tol
    function automatic logic in_tol(input int meas, input int exp_half, input int tol);
        return (meas >= exp_half - tol) && (meas <= exp_half + tol);
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser bringing a single asynchronous bit into the
// clk_i domain. Both stages clear on the asynchronous reset.
module bit_sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Capture the asynchronous input, then re-time it once more
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow-clock monitor: synchronises slow_clk into clk_in, emits rise/fall
// ticks, measures every half-period and tracks lock/stall with a small FSM.
// Optional feature macro: SLOW_CLK_MON_ERRCNT_EN enables the saturating
// error-event counter on err_count; without it err_count is constant zero.
module slow_clk_monitor
    import slow_clk_mon_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int EXP_HALF    = DEF_EXP_HALF,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_EDGES  = DEF_LOCK_EDGES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             lock,
    output logic             stall,
    output logic [7:0]       err_count
);

    localparam int               GOOD_W    = $clog2(LOCK_EDGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   STALL_CMP = (CNT_W + 1)'(STALL_LIMIT);
    localparam logic [CNT_W:0]   ONE_W     = (CNT_W + 1)'(1);

    // Synchronised slow clock (s2) and one extra stage (s3) for edge detect
    logic s2;
    logic s3_q;

    bit_sync_2ff u_sync (
        .clk_i (clk_in),
        .rst_i (reset),
        .d_i   (slow_clk),
        .q_o   (s2)
    );

    logic edge_det;
    logic rise_det;
    logic fall_det;

    assign edge_det = s2 ^ s3_q;
    assign rise_det = edge_det & s2;
    assign fall_det = edge_det & ~s2;

    // Half-period counter; cnt_plus keeps a carry bit so the stall
    // comparison is exact and saturation is easy to detect.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_plus;
    logic [CNT_W-1:0] meas;
    logic             stall_hit;
    logic             meas_ok;

    assign cnt_plus  = {1'b0, cnt_q} + ONE_W;
    assign meas      = cnt_plus[CNT_W] ? CNT_MAX : cnt_plus[CNT_W-1:0];
    assign stall_hit = !edge_det && (cnt_plus == STALL_CMP);
    assign meas_ok   = in_tol(int'(meas), EXP_HALF, TOL);

    mon_state_e        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              upd_d;

    logic             rise_q;
    logic             fall_q;
    logic             pv_q;
    logic [CNT_W-1:0] half_q;
    logic             lock_q;
    logic             stall_q;

    // Next-state logic: an edge always takes priority over the stall timeout
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        upd_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_det) begin
                    state_d = ACQUIRE;
                end else if (stall_hit) begin
                    state_d = STALLED;
                end
            end
            ACQUIRE: begin
                if (edge_det) begin
                    upd_d = 1'b1;
                    if (meas_ok) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_q == GOOD_W'(LOCK_EDGES - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (stall_hit) begin
                    state_d = STALLED;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    upd_d = 1'b1;
                    if (!meas_ok) begin
                        good_d  = '0;
                        state_d = ACQUIRE;
                    end
                end else if (stall_hit) begin
                    state_d = STALLED;
                end
            end
            STALLED: begin
                if (edge_det) begin
                    good_d  = '0;
                    state_d = ACQUIRE;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase
    end

    // FSM state, good-measurement count and the half-period counter
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            good_q  <= '0;
            cnt_q   <= '0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            cnt_q   <= edge_det ? '0 : meas;
            s3_q    <= s2;
        end
    end

    // Registered outputs, all aligned to the cycle after the detected edge
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            pv_q    <= 1'b0;
            half_q  <= '0;
            lock_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            rise_q  <= rise_det;
            fall_q  <= fall_det;
            pv_q    <= upd_d;
            if (upd_d) begin
                half_q <= meas;
            end
            lock_q  <= (state_d == LOCKED);
            stall_q <= (state_d == STALLED);
        end
    end

    assign rise_tick    = rise_q;
    assign fall_tick    = fall_q;
    assign period_valid = pv_q;
    assign half_period  = half_q;
    assign lock         = lock_q;
    assign stall        = stall_q;

`ifdef SLOW_CLK_MON_ERRCNT_EN
    // Error event: out-of-tolerance measurement or entry into STALLED
    logic       err_ev;
    logic [7:0] err_q;

    assign err_ev = (upd_d && !meas_ok) || (stall_hit && (state_q != STALLED));

    // Saturating error counter, cleared only by reset
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            err_q <= 8'd0;
        end else if (err_ev && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

endmodule
